// File: rtl/data_sram_responder_pkg.sv
// Shared types and defaults for the data-side SRAM responder.
package data_sram_responder_pkg;

    // System-wide defaults: word-address width and memory wait states.
    localparam int DATA_SRAM_ADDR_W = 14;
    localparam int MEM_WAIT_CYCLES  = 0;

    typedef enum logic {
        DS_IDLE = 1'b0,
        DS_BUSY = 1'b1
    } ds_state_e;

    // Wait-state down-counter width, never narrower than one bit.
    function automatic int ds_cnt_w(input int wait_cycles);
        int w;
        w = $clog2(wait_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/data_sram_responder_if.sv
// data_sram_* bus between EX/MEM (master) and the data memory (slave).
interface data_sram_responder_if;

    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_en,
        output data_sram_wen,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_en,
        input  data_sram_wen,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );

endinterface

// File: rtl/data_ram_bank.sv
// Four byte-wide synchronous RAM lanes with registered read and no reset.
module data_ram_bank #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    for (genvar lane = 0; lane < 4; lane++) begin : g_lane
        logic [7:0] mem [2**ADDR_W];
        logic [7:0] q;

        // Lane write when enabled; read of idx is registered every cycle.
        always_ff @(posedge clk) begin
            if (we[lane]) begin
                mem[idx] <= wdata[8*lane +: 8];
            end
            q <= mem[idx];
        end

        assign rdata[8*lane +: 8] = q;
    end

endmodule

// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: request latch, wait-state FSM, range check, rdata hold.
module data_sram_responder
    import data_sram_responder_pkg::*;
#(
    parameter int ADDR_W      = DATA_SRAM_ADDR_W,
    parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
    input  logic                 clk,
    input  logic                 rst,
    data_sram_responder_if.slave data_sram,
    output logic                 stallreq,
    output logic                 addr_err
);

    localparam int CNT_W = ds_cnt_w(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    ds_state_e        state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      lat_addr;
    logic [3:0]       lat_wen;
    logic [31:0]      lat_wdata;

    logic             do_acc;
    logic [31:0]      acc_addr;
    logic [3:0]       acc_wen;
    logic [31:0]      acc_wdata;
    logic             in_range;
    logic [3:0]       bank_we;
    logic [31:0]      bank_rdata;

    // rd_done_q marks the cycle the bank output carries a fresh in-range
    // read; otherwise rdata comes from hold_q, which keeps the last result.
    logic             rd_done_q;
    logic [31:0]      hold_q;
    logic             unused_lsbs;

    // Select the access completing at this edge: live request or latched one.
    always_comb begin
        do_acc    = 1'b0;
        acc_addr  = data_sram.data_sram_addr;
        acc_wen   = data_sram.data_sram_wen;
        acc_wdata = data_sram.data_sram_wdata;
        if (WAIT_CYCLES == 0) begin
            do_acc = data_sram.data_sram_en;
        end else begin
            do_acc    = (state == DS_BUSY) && (cnt == '0);
            acc_addr  = lat_addr;
            acc_wen   = lat_wen;
            acc_wdata = lat_wdata;
        end
        in_range = (acc_addr[31:ADDR_W+2] == '0);
        bank_we  = (do_acc && in_range) ? acc_wen : '0;
    end

    assign unused_lsbs = &acc_addr[1:0];

    assign stallreq = (WAIT_CYCLES != 0) && !rst &&
                      (((state == DS_IDLE) && data_sram.data_sram_en) ||
                       ((state == DS_BUSY) && (cnt != '0)));

    assign data_sram.data_sram_rdata = rd_done_q ? bank_rdata : hold_q;

    data_ram_bank #(
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (clk),
        .we    (bank_we),
        .idx   (acc_addr[ADDR_W+1:2]),
        .wdata (acc_wdata),
        .rdata (bank_rdata)
    );

    // Wait-state FSM, request latch, read-result hold and sticky range error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= DS_IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wen   <= '0;
            lat_wdata <= '0;
            rd_done_q <= 1'b0;
            hold_q    <= '0;
            addr_err  <= 1'b0;
        end else begin
            if (rd_done_q) begin
                hold_q <= bank_rdata;
            end
            rd_done_q <= 1'b0;

            if (do_acc) begin
                if (!in_range) begin
                    addr_err <= 1'b1;
                end
                if (acc_wen == '0) begin
                    if (in_range) begin
                        rd_done_q <= 1'b1;
                    end else begin
                        hold_q <= '0;
                    end
                end
            end

            case (state)
                DS_IDLE: begin
                    if (data_sram.data_sram_en && (WAIT_CYCLES != 0)) begin
                        lat_addr  <= data_sram.data_sram_addr;
                        lat_wen   <= data_sram.data_sram_wen;
                        lat_wdata <= data_sram.data_sram_wdata;
                        cnt       <= CNT_LOAD;
                        state     <= DS_BUSY;
                    end
                end
                DS_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= DS_IDLE;
                    end
                end
                default: state <= DS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder at WAIT_CYCLES 0, 2, 3 and 4.
module tb_data_sram_responder;

    logic clk = 1'b0;
    logic rst;
    logic rst4;
    int   checks = 0;
    int   errors = 0;

    logic stall0, stall2, stall3, stall4;
    logic aerr0, aerr2, aerr3, aerr4;

    data_sram_responder_if ifc0 ();
    data_sram_responder_if ifc2 ();
    data_sram_responder_if ifc3 ();
    data_sram_responder_if ifc4 ();

    data_sram_responder #(.ADDR_W(14), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .data_sram(ifc0), .stallreq(stall0), .addr_err(aerr0));
    data_sram_responder #(.ADDR_W(14), .WAIT_CYCLES(2)) u2 (
        .clk(clk), .rst(rst), .data_sram(ifc2), .stallreq(stall2), .addr_err(aerr2));
    data_sram_responder #(.ADDR_W(14), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .data_sram(ifc3), .stallreq(stall3), .addr_err(aerr3));
    data_sram_responder #(.ADDR_W(14), .WAIT_CYCLES(4)) u4 (
        .clk(clk), .rst(rst4), .data_sram(ifc4), .stallreq(stall4), .addr_err(aerr4));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drv0(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
        ifc0.data_sram_en = en; ifc0.data_sram_wen = wen;
        ifc0.data_sram_addr = addr; ifc0.data_sram_wdata = wd;
    endtask

    task automatic drv2(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
        ifc2.data_sram_en = en; ifc2.data_sram_wen = wen;
        ifc2.data_sram_addr = addr; ifc2.data_sram_wdata = wd;
    endtask

    task automatic drv3(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
        ifc3.data_sram_en = en; ifc3.data_sram_wen = wen;
        ifc3.data_sram_addr = addr; ifc3.data_sram_wdata = wd;
    endtask

    task automatic drv4(input logic en, input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd);
        ifc4.data_sram_en = en; ifc4.data_sram_wen = wen;
        ifc4.data_sram_addr = addr; ifc4.data_sram_wdata = wd;
    endtask

    initial begin
        drv0(1'b0, 4'h0, 32'h0, 32'h0);
        drv2(1'b0, 4'h0, 32'h0, 32'h0);
        drv3(1'b0, 4'h0, 32'h0, 32'h0);
        drv4(1'b0, 4'h0, 32'h0, 32'h0);
        rst  = 1'b1;
        rst4 = 1'b1;
        repeat (2) step();

        // Reset state
        chk("rst_rdata0", ifc0.data_sram_rdata, 32'h0);
        chk("rst_stall0", {31'b0, stall0}, 32'h0);
        chk("rst_aerr0",  {31'b0, aerr0}, 32'h0);
        chk("rst_stall3", {31'b0, stall3}, 32'h0);
        chk("rst_rdata4", ifc4.data_sram_rdata, 32'h0);
        rst  = 1'b0;
        rst4 = 1'b0;
        step();

        // ---------------- W=0 ----------------
        drv0(1'b1, 4'hF, 32'h100, 32'hDEADBEEF);
        mid(); chk("w0_wr_stall", {31'b0, stall0}, 32'h0);
        step(); drv0(1'b1, 4'h0, 32'h100, 32'h0);
        mid(); chk("w0_rd_stall", {31'b0, stall0}, 32'h0);
        chk("w0_rdata_before", ifc0.data_sram_rdata, 32'h0);
        step(); drv0(1'b0, 4'h0, 32'h0, 32'h0);
        mid(); chk("w0_rdata_full", ifc0.data_sram_rdata, 32'hDEADBEEF);
        step(); drv0(1'b1, 4'b0010, 32'h100, 32'h0000AB00);
        mid(); chk("w0_rdata_hold_wr", ifc0.data_sram_rdata, 32'hDEADBEEF);
        step(); drv0(1'b1, 4'h0, 32'h100, 32'h0);
        step(); drv0(1'b0, 4'h0, 32'h0, 32'h0);
        mid(); chk("w0_rdata_lane1", ifc0.data_sram_rdata, 32'hDEADABEF);
        chk("w0_aerr_clean", {31'b0, aerr0}, 32'h0);

        // Out-of-range read, then out-of-range write aliasing word 0x40
        step(); drv0(1'b1, 4'h0, 32'h0010_0000, 32'h0);
        step(); drv0(1'b0, 4'h0, 32'h0, 32'h0);
        mid(); chk("oor_rdata", ifc0.data_sram_rdata, 32'h0);
        chk("oor_aerr", {31'b0, aerr0}, 32'h1);
        step(); drv0(1'b1, 4'hF, 32'h0010_0100, 32'h12345678);
        step(); drv0(1'b1, 4'h0, 32'h100, 32'h0);
        step(); drv0(1'b0, 4'h0, 32'h0, 32'h0);
        mid(); chk("oor_wr_dropped", ifc0.data_sram_rdata, 32'hDEADABEF);
        chk("oor_aerr_sticky", {31'b0, aerr0}, 32'h1);

        // Partial lane pattern 4'b0110
        step(); drv0(1'b1, 4'hF, 32'h104, 32'h11223344);
        step(); drv0(1'b1, 4'b0110, 32'h104, 32'hAABBCCDD);
        step(); drv0(1'b1, 4'h0, 32'h104, 32'h0);
        step(); drv0(1'b0, 4'h0, 32'h0, 32'h0);
        mid(); chk("w0_lanes_0110", ifc0.data_sram_rdata, 32'h11BBCC44);

        // ---------------- W=3 ----------------
        step(); drv3(1'b1, 4'hF, 32'h40, 32'hCAFEF00D);
        repeat (3) step();
        step(); drv3(1'b1, 4'h0, 32'h40, 32'h0);
        mid(); chk("w3_stall_c10", {31'b0, stall3}, 32'h1);
        step();
        mid(); chk("w3_stall_c11", {31'b0, stall3}, 32'h1);
        step();
        mid(); chk("w3_stall_c12", {31'b0, stall3}, 32'h1);
        step();
        mid(); chk("w3_stall_c13", {31'b0, stall3}, 32'h0);
        chk("w3_rdata_c13", ifc3.data_sram_rdata, 32'h0);
        step(); drv3(1'b0, 4'h0, 32'h0, 32'h0);
        mid(); chk("w3_rdata_c14", ifc3.data_sram_rdata, 32'hCAFEF00D);
        chk("w3_stall_c14", {31'b0, stall3}, 32'h0);
        step();
        mid(); chk("w3_rdata_hold", ifc3.data_sram_rdata, 32'hCAFEF00D);

        // ---------------- W=2 back-to-back ----------------
        step(); drv2(1'b1, 4'hF, 32'h8, 32'h0BADCAFE);
        mid(); chk("w2_wr_stall0", {31'b0, stall2}, 32'h1);
        step();
        mid(); chk("w2_wr_stall1", {31'b0, stall2}, 32'h1);
        step();
        mid(); chk("w2_wr_done", {31'b0, stall2}, 32'h0);
        step(); drv2(1'b1, 4'h0, 32'h8, 32'h0);
        mid(); chk("w2_rd_accept", {31'b0, stall2}, 32'h1);
        step();
        mid(); chk("w2_rd_stall1", {31'b0, stall2}, 32'h1);
        step();
        mid(); chk("w2_rd_done", {31'b0, stall2}, 32'h0);
        step(); drv2(1'b0, 4'h0, 32'h0, 32'h0);
        mid(); chk("w2_rdata", ifc2.data_sram_rdata, 32'h0BADCAFE);

        // ---------------- W=4 reset mid-BUSY ----------------
        step(); drv4(1'b1, 4'hF, 32'h20, 32'h01020304);
        repeat (4) step();
        step(); drv4(1'b1, 4'h0, 32'h20, 32'h0);
        repeat (4) step();
        step(); drv4(1'b0, 4'h0, 32'h0, 32'h0);
        mid(); chk("w4_rdata_pre", ifc4.data_sram_rdata, 32'h01020304);
        step(); drv4(1'b1, 4'hF, 32'h20, 32'hFFFFFFFF);
        step();
        step(); drv4(1'b0, 4'h0, 32'h0, 32'h0);
        chk("w4_stall_busy2", {31'b0, stall4}, 32'h1);
        rst4 = 1'b1;
        #1;
        chk("w4_rst_stall", {31'b0, stall4}, 32'h0);
        chk("w4_rst_rdata", ifc4.data_sram_rdata, 32'h0);
        step(); rst4 = 1'b0;
        step(); drv4(1'b1, 4'h0, 32'h20, 32'h0);
        repeat (4) step();
        step(); drv4(1'b0, 4'h0, 32'h0, 32'h0);
        mid(); chk("w4_write_discarded", ifc4.data_sram_rdata, 32'h01020304);
        chk("w4_aerr", {31'b0, aerr4}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
